// File: rtl/fast_square_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fast_square_pkg
//  Purpose  : Shared definitions for the frequency-step decoder: decode state
//             encoding, phase counter width, idle timer width, index width.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package fast_square_pkg;

    localparam int c_PHASE_W = 5;
    localparam int c_TIMER_W = 20;
    localparam int c_INDEX_W = 8;

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_P1   = 3'd1;
    localparam logic [2:0] c_ST_GAP  = 3'd2;
    localparam logic [2:0] c_ST_P2   = 3'd3;
    localparam logic [2:0] c_ST_ERR  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE = c_ST_IDLE,
        ST_P1   = c_ST_P1,
        ST_GAP  = c_ST_GAP,
        ST_P2   = c_ST_P2,
        ST_ERR  = c_ST_ERR
    } decode_state_e;

endpackage
`default_nettype wire

// File: rtl/fast_square_pulse_filter.sv
`default_nettype none
// ============================================================================
//  Module   : fast_square_pulse_filter
//  Purpose  : Recognises the double-pulse step symbol on the step line.
//             Owns the optional input synchronizer, the 5-bit phase counter
//             and the decode FSM; emits single-cycle commit/error pulses
//             (combinational, registered by the parent).
//  Macro    : FREQ_STEP_SYNC_EN - when defined, a 2-flop synchronizer sits
//             in front of the decoder.
//  Ports    : clock, reset (sync, active-high)
//             i_step   - raw step line
//             o_commit - valid symbol completed this cycle
//             o_error  - malformed symbol detected this cycle
//  Revision : 1.0 - initial release
// ============================================================================
module fast_square_pulse_filter #(
    parameter int MIN_PULSE = 4,
    parameter int MAX_PULSE = 16,
    parameter int MIN_GAP   = 4,
    parameter int MAX_GAP   = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic i_step,
    output logic o_commit,
    output logic o_error
);
    import fast_square_pkg::*;

    localparam logic [c_PHASE_W-1:0] c_MIN_PULSE = c_PHASE_W'(MIN_PULSE);
    localparam logic [c_PHASE_W-1:0] c_MAX_PULSE = c_PHASE_W'(MAX_PULSE);
    localparam logic [c_PHASE_W-1:0] c_MIN_GAP   = c_PHASE_W'(MIN_GAP);
    localparam logic [c_PHASE_W-1:0] c_MAX_GAP   = c_PHASE_W'(MAX_GAP);
    localparam logic [c_PHASE_W-1:0] c_CNT_MAX   = '1;

    logic                 w_in;
    logic                 r_armed;
    decode_state_e        r_state, w_state_nxt;
    logic [c_PHASE_W-1:0] r_count, w_count_nxt, w_count_inc;

`ifdef FREQ_STEP_SYNC_EN
    // Synchronizer flops are deliberately not reset: after a reset they keep
    // tracking the real line level, so a pulse in progress cannot arm the
    // decoder through a false low.
    logic r_sync_q1, r_sync_q2;
    always_ff @(posedge clock) begin
        r_sync_q1 <= i_step;
        r_sync_q2 <= r_sync_q1;
    end
    assign w_in = r_sync_q2;
`else
    assign w_in = i_step;
`endif

    // Armed once a low has been seen since reset, so the tail of a symbol
    // cut by reset is never mistaken for a new first pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_armed <= 1'b0;
        end else if (!w_in) begin
            r_armed <= 1'b1;
        end
    end

    assign w_count_inc = (r_count == c_CNT_MAX) ? r_count : r_count + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Counter clears on every state change; only IDLE->P1 starts at 1 so the
    // first high sample is counted.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = w_count_inc;
        o_commit    = 1'b0;
        o_error     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_count_nxt = '0;
                if (w_in && r_armed) begin
                    w_state_nxt = ST_P1;
                    w_count_nxt = c_PHASE_W'(1);
                end
            end
            ST_P1, ST_P2: begin
                if (w_in) begin
                    if (w_count_inc >= c_MAX_PULSE) begin
                        w_state_nxt = ST_ERR;
                        w_count_nxt = '0;
                        o_error     = 1'b1;
                    end
                end else begin
                    w_count_nxt = '0;
                    if (r_count < c_MIN_PULSE) begin
                        w_state_nxt = ST_ERR;
                        o_error     = 1'b1;
                    end else if (r_state == ST_P1) begin
                        w_state_nxt = ST_GAP;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        o_commit    = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (!w_in) begin
                    if (w_count_inc > c_MAX_GAP) begin
                        w_state_nxt = ST_ERR;
                        w_count_nxt = '0;
                        o_error     = 1'b1;
                    end
                end else begin
                    w_count_nxt = '0;
                    if (r_count >= c_MIN_GAP) begin
                        w_state_nxt = ST_P2;
                    end else begin
                        w_state_nxt = ST_ERR;
                        o_error     = 1'b1;
                    end
                end
            end
            ST_ERR: begin
                // Any high restarts the quiet-line requirement.
                if (w_in) begin
                    w_count_nxt = '0;
                end else if (w_count_inc >= c_MIN_GAP) begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/fast_square_step_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : fast_square_step_decoder
//  Purpose  : Receive-side frequency-step decoder. Tracks the sweep frequency
//             index from double-pulse step symbols, wraps at the end of the
//             sweep, returns to index 0 after an idle timeout and reports
//             decode errors.
//  Macro    : FREQ_STEP_SYNC_EN (see fast_square_pulse_filter)
//  Ports    : clock, reset (sync, active-high)
//             freq_step_in - step line from the sweep controller
//             freq_index   - current frequency index
//             step_strobe  - 1-cycle pulse on every committed step
//             sweep_start  - 1-cycle pulse when index returns to 0 (wrap/timeout)
//             resync_req   - 1-cycle pulse on each decode error
//             err_count    - saturating decode error count
//  Revision : 1.0 - initial release
// ============================================================================
module fast_square_step_decoder #(
    parameter int NUM_FREQ_STEPS = 32,
    parameter int MIN_PULSE      = 4,
    parameter int MAX_PULSE      = 16,
    parameter int MIN_GAP        = 4,
    parameter int MAX_GAP        = 16,
    parameter int IDLE_TIMEOUT   = 65536
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       freq_step_in,
    output logic [7:0] freq_index,
    output logic       step_strobe,
    output logic       sweep_start,
    output logic       resync_req,
    output logic [7:0] err_count
);
    import fast_square_pkg::*;

    localparam logic [c_INDEX_W-1:0] c_LAST_INDEX = c_INDEX_W'(NUM_FREQ_STEPS - 1);
    localparam logic [c_TIMER_W-1:0] c_TIMEOUT    = c_TIMER_W'(IDLE_TIMEOUT);

    logic                 w_commit, w_error;
    logic [c_INDEX_W-1:0] r_freq_index, r_err_count;
    logic [c_TIMER_W-1:0] r_timer, w_timer_inc;
    logic                 r_step_strobe, r_sweep_start, r_resync_req;

    fast_square_pulse_filter #(
        .MIN_PULSE (MIN_PULSE),
        .MAX_PULSE (MAX_PULSE),
        .MIN_GAP   (MIN_GAP),
        .MAX_GAP   (MAX_GAP)
    ) u_filter (
        .clock    (clock),
        .reset    (reset),
        .i_step   (freq_step_in),
        .o_commit (w_commit),
        .o_error  (w_error)
    );

    assign w_timer_inc = r_timer + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_freq_index  <= '0;
            r_err_count   <= '0;
            r_timer       <= '0;
            r_step_strobe <= 1'b0;
            r_sweep_start <= 1'b0;
            r_resync_req  <= 1'b0;
        end else begin
            r_step_strobe <= 1'b0;
            r_sweep_start <= 1'b0;
            r_resync_req  <= w_error;
            if (w_error && (r_err_count != '1)) begin
                r_err_count <= r_err_count + 1'b1;
            end
            // Commit takes priority over a coincident timeout.
            if (w_commit) begin
                r_timer       <= '0;
                r_step_strobe <= 1'b1;
                if (r_freq_index == c_LAST_INDEX) begin
                    r_freq_index  <= '0;
                    r_sweep_start <= 1'b1;
                end else begin
                    r_freq_index <= r_freq_index + 1'b1;
                end
            end else if (r_freq_index == '0) begin
                r_timer <= '0;
            end else if (w_timer_inc == c_TIMEOUT) begin
                r_freq_index  <= '0;
                r_sweep_start <= 1'b1;
                r_timer       <= '0;
            end else begin
                r_timer <= w_timer_inc;
            end
        end
    end

    assign freq_index  = r_freq_index;
    assign err_count   = r_err_count;
    assign step_strobe = r_step_strobe;
    assign sweep_start = r_sweep_start;
    assign resync_req  = r_resync_req;

endmodule
`default_nettype wire

// File: tb/tb_fast_square_step_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fast_square_step_decoder
//  Purpose  : Self-checking bench for fast_square_step_decoder (default build,
//             no input synchronizer). Table of symbol shapes plus directed
//             sequences for latency, wrap, timeout and reset corner cases.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fast_square_step_decoder;

    localparam int c_T     = 256;
    localparam int c_STEPS = 32;

    logic       clock = 1'b0;
    logic       reset;
    logic       freq_step_in;
    logic [7:0] freq_index;
    logic       step_strobe;
    logic       sweep_start;
    logic       resync_req;
    logic [7:0] err_count;

    int total = 0;
    int bad   = 0;
    int n_str = 0;
    int n_rsy = 0;
    int exp_idx;
    int exp_err;

    typedef struct {
        int p1;
        int gap;
        int p2;
        int n_commit;
        int n_err;
    } vec_t;

    vec_t vecs[9];

    fast_square_step_decoder #(
        .NUM_FREQ_STEPS (c_STEPS),
        .IDLE_TIMEOUT   (c_T)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .freq_step_in (freq_step_in),
        .freq_index   (freq_index),
        .step_strobe  (step_strobe),
        .sweep_start  (sweep_start),
        .resync_req   (resync_req),
        .err_count    (err_count)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (step_strobe) n_str++;
        if (resync_req)  n_rsy++;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One value per cycle; returns 1 time unit after the sampling edge.
    task automatic drive(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            freq_step_in = v;
            @(posedge clock);
            #1;
        end
    endtask

    // Controller-shaped symbol; returns just after the commit edge.
    task automatic symbol();
        drive(1'b1, 10);
        drive(1'b0, 11);
        drive(1'b1, 9);
        drive(1'b0, 1);
    endtask

    initial begin
        int s0, r0;
        vecs[0] = '{10, 11,  9, 1, 0};
        vecs[1] = '{ 4,  5,  5, 1, 0};
        vecs[2] = '{ 3,  0,  0, 0, 1};
        vecs[3] = '{10,  3,  6, 0, 1};
        vecs[4] = '{10,  6,  3, 0, 1};
        vecs[5] = '{15,  6,  6, 1, 0};
        vecs[6] = '{16,  0,  0, 0, 1};
        vecs[7] = '{10, 16,  6, 1, 0};
        vecs[8] = '{10, 20,  0, 0, 1};

        // Reset state
        reset        = 1'b1;
        freq_step_in = 1'b0;
        drive(1'b0, 3);
        reset = 1'b0;
        check("rst_idx",    freq_index,  0);
        check("rst_strobe", step_strobe, 0);
        check("rst_sweep",  sweep_start, 0);
        check("rst_resync", resync_req,  0);
        check("rst_err",    err_count,   0);
        drive(1'b0, 2);

        // First symbol: commit appears right after first low following P2
        drive(1'b1, 10);
        drive(1'b0, 11);
        drive(1'b1, 9);
        check("pre_commit_strobe", step_strobe, 0);
        check("pre_commit_idx",    freq_index,  0);
        drive(1'b0, 1);
        check("commit_strobe", step_strobe, 1);
        check("commit_idx",    freq_index,  1);
        check("commit_sweep",  sweep_start, 0);
        drive(1'b0, 1);
        check("strobe_width",  step_strobe, 0);
        check("sym_no_resync", n_rsy, 0);

        // Glitch of 2 high cycles
        drive(1'b1, 2);
        drive(1'b0, 1);
        check("glitch_resync", resync_req, 1);
        check("glitch_err",    err_count,  1);
        check("glitch_idx",    freq_index, 1);
        drive(1'b0, 1);
        check("resync_width",  resync_req, 0);
        drive(1'b0, 6);

        // Stuck pulse: error on the MAX_PULSE-th high sample
        drive(1'b1, 15);
        check("stuck15_resync", resync_req, 0);
        r0 = n_rsy;
        drive(1'b1, 1);
        check("stuck16_resync", resync_req, 1);
        check("stuck_err",      err_count,  2);
        drive(1'b1, 4);
        drive(1'b0, 8);
        check("stuck_one_err",  n_rsy - r0, 1);

        // Table of symbol shapes
        exp_idx = 1;
        exp_err = 2;
        for (int k = 0; k < 9; k++) begin
            s0 = n_str;
            r0 = n_rsy;
            drive(1'b1, vecs[k].p1);
            if (vecs[k].gap > 0) drive(1'b0, vecs[k].gap);
            if (vecs[k].p2 > 0)  drive(1'b1, vecs[k].p2);
            drive(1'b0, 8);
            exp_idx = (exp_idx + vecs[k].n_commit) % c_STEPS;
            exp_err = (exp_err + vecs[k].n_err > 255) ? 255 : exp_err + vecs[k].n_err;
            check("vec_commits", n_str - s0, vecs[k].n_commit);
            check("vec_errors",  n_rsy - r0, vecs[k].n_err);
            check("vec_idx",     freq_index, exp_idx);
            check("vec_err_cnt", err_count,  exp_err);
        end

        // Idle timeout
        symbol();
        exp_idx = exp_idx + 1;
        check("to_pre_idx", freq_index, exp_idx);
        drive(1'b0, c_T - 1);
        check("to_before_idx",   freq_index,  exp_idx);
        check("to_before_sweep", sweep_start, 0);
        drive(1'b0, 1);
        check("to_idx",   freq_index,  0);
        check("to_sweep", sweep_start, 1);
        drive(1'b0, 1);
        check("to_sweep_width", sweep_start, 0);

        // Commit landing on the timeout cycle
        symbol();
        check("ct_idx1", freq_index, 1);
        drive(1'b0, c_T - 31);
        symbol();
        check("ct_idx",    freq_index,  2);
        check("ct_strobe", step_strobe, 1);
        check("ct_sweep",  sweep_start, 0);
        drive(1'b0, c_T - 1);
        check("ct_hold_idx", freq_index, 2);
        drive(1'b0, 1);
        check("ct_to_idx",   freq_index,  0);
        check("ct_to_sweep", sweep_start, 1);

        // Full sweep and wrap
        for (int k = 1; k < c_STEPS; k++) begin
            symbol();
            check("sweep_idx",   freq_index,  k);
            check("sweep_nosws", sweep_start, 0);
        end
        symbol();
        check("wrap_idx",    freq_index,  0);
        check("wrap_sweep",  sweep_start, 1);
        check("wrap_strobe", step_strobe, 1);
        drive(1'b0, 1);
        check("wrap_sweep_width", sweep_start, 0);

        // Reset during P2
        symbol();
        drive(1'b1, 10);
        drive(1'b0, 11);
        drive(1'b1, 3);
        reset = 1'b1;
        drive(1'b1, 1);
        reset = 1'b0;
        check("midrst_idx",    freq_index,  0);
        check("midrst_err",    err_count,   0);
        check("midrst_strobe", step_strobe, 0);
        check("midrst_sweep",  sweep_start, 0);
        check("midrst_resync", resync_req,  0);
        s0 = n_str;
        r0 = n_rsy;
        drive(1'b1, 5);
        drive(1'b0, 8);
        check("tail_no_step",  n_str - s0, 0);
        check("tail_no_error", n_rsy - r0, 0);
        symbol();
        check("after_rst_idx", freq_index, 1);
        check("after_rst_err", err_count,  0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
